// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB defaults, accelerator control-register map and master state type
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    // Accelerator control register and its bit-field offsets
    localparam logic [31:0] CTRL_ADDR         = 32'h0000_0000;
    localparam int          CTRL_START_BIT    = 0;
    localparam int          CTRL_MODE_BIT     = 1;
    localparam int          CTRL_TARGETS_LSB  = 2;
    localparam int          CTRL_DATAFLOW_LSB = 4;
    localparam int          CTRL_DIM_N_LSB    = 8;
    localparam int          CTRL_DIM_K_LSB    = 14;
    localparam int          CTRL_DIM_M_LSB    = 20;
    localparam int          CTRL_RELOAD_A_BIT = 26;
    localparam int          CTRL_RELOAD_B_BIT = 27;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_watchdog.sv
// rtl/apb_watchdog.sv - wait-state counter that flags when a slave has stalled too long
module apb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] count_q;

    // Count unanswered ACCESS cycles; clear has priority so each transfer starts from zero
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Expiry is judged in the cycle the count reaches its last allowed value
    assign expired_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_cfg_master.sv
// rtl/apb_cfg_master.sv - single-outstanding APB initiator with held response and watchdog abort
module apb_cfg_master
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    rsp_timeout_o,
    output logic                    psel_o,
    output logic                    penable_o,
    output logic                    pwrite_o,
    output logic [ADDR_WIDTH-1:0]   paddr_o,
    output logic [DATA_WIDTH-1:0]   pwdata_o,
    output logic [DATA_WIDTH/8-1:0] pstrb_o,
    input  logic [DATA_WIDTH-1:0]   prdata_i,
    input  logic                    pready_i,
    input  logic                    pslverr_i
);

    localparam int STRB_W = DATA_WIDTH / 8;

    apb_state_t              state_q;
    logic                    cmd_ready_q;
    logic                    psel_q;
    logic                    penable_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_W-1:0]       pstrb_q;
    logic                    rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;
    logic                    rsp_timeout_q;
    logic                    wd_expired;

    // Watchdog runs only while ACCESS waits on the slave; it is zero in every other state
    apb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (state_q != ACCESS),
        .inc_i     (!pready_i),
        .expired_o (wd_expired)
    );

    // Transfer FSM; every output is a register so the APB and host sides see glitch-free signals
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_ready_q && cmd_valid_i) begin
                        state_q     <= SETUP;
                        cmd_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        pwrite_q    <= cmd_write_i;
                        paddr_q     <= cmd_addr_i;
                        pwdata_q    <= cmd_wdata_i;
                        pstrb_q     <= cmd_write_i ? cmd_strb_i : '0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    // A ready slave beats a watchdog expiring in the same cycle
                    if (pready_i) begin
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= pslverr_i;
                        rsp_timeout_q <= 1'b0;
                        rsp_rdata_q   <= (!pwrite_q && !pslverr_i) ? prdata_i : '0;
                    end else if (wd_expired) begin
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        rsp_rdata_q   <= '0;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign psel_o        = psel_q;
    assign penable_o     = penable_q;
    assign pwrite_o      = pwrite_q;
    assign paddr_o       = paddr_q;
    assign pwdata_o      = pwdata_q;
    assign pstrb_o       = pstrb_q;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    assign rsp_timeout_o = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb/tb_apb_cfg_master.sv - randomized self-checking bench with slave memory model
module tb_apb_cfg_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [DW-1:0] prdata;
    logic          pready, pslverr;

    always #5 clk = ~clk;

    apb_cfg_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .cmd_strb_i    (cmd_strb),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .rsp_timeout_o (rsp_timeout),
        .psel_o        (psel),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .paddr_o       (paddr),
        .pwdata_o      (pwdata),
        .pstrb_o       (pstrb),
        .prdata_i      (prdata),
        .pready_i      (pready),
        .pslverr_i     (pslverr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Register file of the modelled APB slave: 16 words at word-aligned addresses
    logic [31:0] mem [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete command: issue, act as slave with `waits` wait states, check response, hold, release
    task automatic run_cmd(input logic wr, input logic [3:0] idx, input logic [31:0] wdata,
                           input logic [3:0] strb, input int waits, input logic serr, input int hold);
        logic [31:0] addr;
        logic        to;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] r_rdata;
        logic        r_err, r_to;
        int          lat, pen, setup, acc, guard;
        addr  = {26'd0, idx, 2'b00};
        to    = (waits >= TO);
        lat   = 0; pen = 0; setup = 0; acc = 0; guard = 0;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 60) begin
            if (psel) begin
                check("paddr", paddr, addr);
                check("pwrite", 32'(pwrite), 32'(wr));
                check("pstrb", 32'(pstrb), wr ? 32'(strb) : 32'd0);
                if (wr) check("pwdata", pwdata, wdata);
                if (penable) pen++;
                else if (pen == 0) setup++;
                else check("psel_without_penable_after_access", 32'(penable), 32'd1);
            end else begin
                check("penable_without_psel", 32'(penable), 32'd0);
            end
            if (psel && penable) begin
                pready = (acc == waits);
                acc++;
            end else begin
                pready = 1'($urandom);
            end
            pslverr = (pready && psel && penable) ? serr : 1'($urandom);
            prdata  = (pready && psel && penable) ? mem[idx] : $urandom;
            @(negedge clk);
            lat++;
        end
        pready = 1'b0;
        check("latency", 32'(lat), to ? 32'(TO + 2) : 32'(waits + 3));
        check("setup_cycles", 32'(setup), 32'd1);
        check("access_cycles", 32'(pen), to ? 32'(TO) : 32'(waits + 1));
        exp_err   = to ? 1'b1 : serr;
        exp_rdata = (to || wr || serr) ? 32'd0 : mem[idx];
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_err", 32'(rsp_err), 32'(exp_err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(to));
        check("psel_in_resp", 32'({psel, penable}), 32'd0);
        r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
        if (wr && !serr && !to) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_ctrl", 32'({rsp_valid, cmd_ready, psel, rsp_err, rsp_timeout}),
                  32'({1'b1, 1'b0, 1'b0, r_err, r_to}));
            check("hold_rdata", rsp_rdata, r_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_cleared", 32'(rsp_valid), 32'd0);
        check("ready_after_rsp", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        logic [3:0] ridx;
        int         rwaits;
        for (int i = 0; i < 16; i++) mem[i] = $urandom;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({cmd_ready, rsp_valid, rsp_err, rsp_timeout, psel, penable, pwrite}), 32'd0);
        check("reset_paddr", paddr, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(cmd_ready), 32'd1);

        // zero-wait write, 3-wait read, slave error on control register
        run_cmd(1'b1, 4'd0, 32'h0000_0101, 4'hF, 0, 1'b0, 0);
        mem[0] = 32'h0000_2A5D;
        run_cmd(1'b0, 4'd0, 32'h0, 4'h0, 3, 1'b0, 0);
        run_cmd(1'b1, 4'd0, 32'h0000_0001, 4'hF, 1, 1'b1, 0);
        // read error forces rdata to zero
        run_cmd(1'b0, 4'd5, 32'h0, 4'h0, 2, 1'b1, 0);
        // stuck slave, and the two edges of the watchdog window
        run_cmd(1'b0, 4'd3, 32'h0, 4'h0, 1000, 1'b0, 0);
        run_cmd(1'b0, 4'd4, 32'h0, 4'h0, TO - 1, 1'b0, 0);
        run_cmd(1'b1, 4'd4, 32'hDEAD_BEEF, 4'hF, TO, 1'b0, 0);
        // held response
        run_cmd(1'b0, 4'd4, 32'h0, 4'h0, 1, 1'b0, 10);

        // reset in the middle of an ACCESS phase
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h8; cmd_wdata = '0; cmd_strb = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        pready = 1'b0;
        @(negedge clk);
        check("in_access_before_reset", 32'({psel, penable}), 32'd3);
        #2 rst_n = 1'b0;
        #1 check("async_drop", 32'({psel, penable, rsp_valid, cmd_ready}), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("no_rsp_in_reset", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset_release", 32'(cmd_ready), 32'd1);
        check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
        run_cmd(1'b0, 4'd2, 32'h0, 4'h0, 0, 1'b0, 0);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            ridx   = 4'($urandom);
            rwaits = ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 4);
            run_cmd(1'($urandom), ridx, $urandom, 4'($urandom), rwaits,
                    ($urandom_range(0, 5) == 0), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
